signed_sort4_ctrl: RTL and testbench
====================================

# signed_sort4_ctrl

Sequencer that sorts four W-bit two's-complement words into ascending order using one shared signed less-than compare unit, fed by a fixed bubble-sort compare-swap schedule. It sits above the subtract-based comparator datapath, where signed less-than is `N xor V` of `a + ~b + 1`. Each cycle it steers one adjacent pair into that unit and conditionally swaps the pair. A start/ready/done handshake connects it to the surrounding control logic.

## Interface
- `W`, default 4: word width. The compare datapath is W bits wide.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a sort. Sampled only while `ready`=1.
- `in_data`  in  4*W  four operands. Lane i is `in_data[i*W +: W]`, signed.
- `ready`  out  1  high in IDLE only.
- `busy`  out  1  high while compare steps are in progress.
- `done`  out  1  one-cycle pulse: `out_data` and `swap_count` are valid.
- `out_data`  out  4*W  sorted result. Lane 0 holds the smallest value. Held until the next sort completes.
- `swap_count`  out  3  number of swaps performed in the last sort, 0..6.

## Operation
- States:
  - IDLE: `ready`=1.
  - SORT: step counter s = 0..5.
  - DONE: lasts one cycle.
- IDLE→SORT occurs on `start`=1. The four lanes are captured into working registers r0..r3, and the swap counter and pass-swap flag are cleared.
- Fixed schedule:
  - s0: (r0,r1); s1: (r1,r2); s2: (r2,r3).
  - s3: (r0,r1); s4: (r1,r2).
  - s5: (r0,r1).
- Each step:
  - Compare the pair with a=r[j+1], b=r[j].
  - lt = signed(a < b), computed as sum[W-1] xor (c[W-1] xor c[W-2]) of a + ~b + 1.
  - If lt=1: swap the pair, increment `swap_count`, set the pass-swap flag.
- Equal values are never swapped, so the sort is stable. The comparison must be correct for all 2^(2W) operand pairs, including the overflow cases (e.g. 7 vs −8).
- After s5, go to DONE. On DONE entry, `out_data` ← r0..r3 and `swap_count` is latched.
- DONE→IDLE is unconditional.
- `start` is ignored in SORT and DONE. No queueing, no restart.
- `in_data` is only sampled at the IDLE start edge. Later changes have no effect.
- Asynchronous reset at any time, including mid-sort:
  - State → IDLE.
  - `ready`=1, `busy`=0, `done`=0, `out_data`=0, `swap_count`=0.
  - Working registers are cleared.

## Timing
- Edge E0: `start` accepted. From E0, `busy`=1 and `ready`=0.
- Edges E1..E6: steps s0..s5.
- After E6: `done`=1, `busy`=0, outputs valid.
- After E7: `ready`=1.
- Latency from start to done: 6 cycles after the accepting edge (7 edges total, E0..E6). One sort every 8 cycles at best.
- `done` is exactly one cycle wide. `busy` and `done` are never both high.

## Configuration
- `SORT_EARLY_EXIT_EN` defined:
  - At the end of a pass (after s2, and after s4), if the pass-swap flag is 0, go to DONE immediately.
  - The flag is cleared at each pass start.
  - Already-sorted input gives `done` after E3.
  - Latency is data-dependent: 3, 5 or 6 steps.
- `SORT_EARLY_EXIT_EN` undefined:
  - All 6 steps always run.
  - Latency is fixed as above.
  - The pass-swap flag may be removed.
- Results (`out_data`, `swap_count`) are identical in both builds.

## Test plan
- Reset: assert `rst_n`=0 with random inputs → `ready`=1, `busy`=0, `done`=0, `out_data`=0, `swap_count`=0.
- Reverse order, lanes {7,3,0,−8} → `out_data` lanes {−8,0,3,7}, `swap_count`=6, `done` after E6.
- Overflow extremes, lanes {1,−8,7,−1} → lanes {−8,−1,1,7}, `swap_count`=3.
- Sorted input with duplicates, lanes {−2,−2,5,5} → unchanged, `swap_count`=0. `done` after E6 without `SORT_EARLY_EXIT_EN`; after E3 with it.
- Pulse `start` at E2 of a sort with different `in_data` → ignored. First result unchanged; next sort accepted only once `ready`=1.
- Drop `rst_n` between E3 and E4 → immediate IDLE, no `done` pulse. A fresh start then sorts correctly.

Source files
------------

// File: rtl/signed_sort4_ctrl_if.sv
// Handshake and data bundle between the sort sequencer and its controller.
// Pure wiring, zero latency; start is only honoured while ready is high.
// master drives start/in_data, slave returns status and the sorted result.
interface signed_sort4_ctrl_if #(
    parameter int W = 4
);
    logic           start;
    logic [4*W-1:0] in_data;
    logic           ready;
    logic           busy;
    logic           done;
    logic [4*W-1:0] out_data;
    logic [2:0]     swap_count;

    modport master (
        output start, in_data,
        input  ready, busy, done, out_data, swap_count
    );

    modport slave (
        input  start, in_data,
        output ready, busy, done, out_data, swap_count
    );
endinterface

// File: rtl/signed_sort4_ctrl.sv
// Ascending signed sort of four words via one shared N^V compare unit (optional SORT_EARLY_EXIT_EN).
// Latency: 6 compare steps after the accepting edge (3/5/6 with SORT_EARLY_EXIT_EN), done pulse 1 cycle.
// Backpressure: start is accepted only in IDLE (ready=1); requests while busy/done are dropped.
module signed_sort4_ctrl #(
    parameter int W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    signed_sort4_ctrl_if.slave  sif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [2:0]     step;
    logic [W-1:0]   r     [4];
    logic [W-1:0]   r_nxt [4];
    logic [2:0]     swap_cnt;
    logic [1:0]     j;
    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic [W-1:0]   nb;
    logic           cy;
    logic           c_msb_in;
    logic           c_msb_out;
    logic           lt;
    logic           last_step;
`ifdef SORT_EARLY_EXIT_EN
    logic           pass_swap;
    logic           pass_end;
`endif

    // Bubble schedule: pass 1 = pairs 0,1,2; pass 2 = pairs 0,1; pass 3 = pair 0.
    always_comb begin
        case (step)
            3'd0, 3'd3, 3'd5: j = 2'd0;
            3'd1, 3'd4:       j = 2'd1;
            default:          j = 2'd2;
        endcase
        opa = r[j + 2'd1];
        opb = r[j];
    end

    // a + ~b + 1; only the sign bit and the two top carries are needed for N xor V.
    always_comb begin
        nb = ~opb;
        cy = 1'b1;
        for (int i = 0; i < W - 1; i++) begin
            cy = (opa[i] & nb[i]) | (opa[i] & cy) | (nb[i] & cy);
        end
        c_msb_in  = cy;
        c_msb_out = (opa[W-1] & nb[W-1]) | (opa[W-1] & c_msb_in) | (nb[W-1] & c_msb_in);
        lt        = (opa[W-1] ^ nb[W-1] ^ c_msb_in) ^ (c_msb_out ^ c_msb_in);
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            r_nxt[i] = r[i];
        end
        if (lt) begin
            r_nxt[j]        = opa;
            r_nxt[j + 2'd1] = opb;
        end
    end

    assign last_step = (step == 3'd5);
`ifdef SORT_EARLY_EXIT_EN
    assign pass_end  = (step == 3'd2) || (step == 3'd4);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sif.ready = 1'b0;
        sif.busy  = 1'b0;
        sif.done  = 1'b0;
        case (state)
            IDLE: begin
                sif.ready = 1'b1;
                if (sif.start) begin
                    state_nxt = SORT;
                end
            end
            SORT: begin
                sif.busy = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
`ifdef SORT_EARLY_EXIT_EN
                else if (pass_end && !(pass_swap || lt)) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                sif.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step           <= 3'd0;
            swap_cnt       <= 3'd0;
            sif.out_data   <= '0;
            sif.swap_count <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r[i] <= '0;
            end
`ifdef SORT_EARLY_EXIT_EN
            pass_swap      <= 1'b0;
`endif
        end else begin
            if (state == IDLE && sif.start) begin
                step     <= 3'd0;
                swap_cnt <= 3'd0;
                for (int i = 0; i < 4; i++) begin
                    r[i] <= sif.in_data[i*W +: W];
                end
`ifdef SORT_EARLY_EXIT_EN
                pass_swap <= 1'b0;
`endif
            end else if (state == SORT) begin
                step     <= step + 3'd1;
                swap_cnt <= swap_cnt + {2'b00, lt};
                for (int i = 0; i < 4; i++) begin
                    r[i] <= r_nxt[i];
                end
`ifdef SORT_EARLY_EXIT_EN
                pass_swap <= pass_end ? 1'b0 : (pass_swap | lt);
`endif
                // Latch results on DONE entry, including the swap made this very step.
                if (state_nxt == DONE) begin
                    sif.swap_count <= swap_cnt + {2'b00, lt};
                    for (int i = 0; i < 4; i++) begin
                        sif.out_data[i*W +: W] <= r_nxt[i];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_signed_sort4_ctrl.sv
// Directed bench for signed_sort4_ctrl with a per-cycle reference model check.
// The model sorts by value and counts inversions; it never mirrors the step schedule.
module tb_signed_sort4_ctrl;
    localparam int W = 4;

`ifdef SORT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;

    signed_sort4_ctrl_if #(.W(W)) sif ();

    signed_sort4_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack4(input int a, input int b, input int c, input int d);
        return {d[3:0], c[3:0], b[3:0], a[3:0]};
    endfunction

    // Result = values in ascending order; swaps = inversion count;
    // passes needed = max number of larger values sitting left of any element.
    task automatic model_sort(input logic [15:0] in, output logic [15:0] o,
                              output int sw, output int lat);
        int v[4];
        int s[4];
        int m;
        int t;
        int cnt;
        for (int i = 0; i < 4; i++) begin
            v[i] = int'($signed(in[i*4 +: 4]));
            s[i] = v[i];
        end
        for (int i = 1; i < 4; i++) begin
            for (int k = i; k > 0; k--) begin
                if (s[k] < s[k-1]) begin
                    t = s[k]; s[k] = s[k-1]; s[k-1] = t;
                end
            end
        end
        sw = 0;
        m  = 0;
        for (int jj = 0; jj < 4; jj++) begin
            cnt = 0;
            for (int ii = 0; ii < jj; ii++) begin
                if (v[ii] > v[jj]) cnt++;
            end
            sw += cnt;
            if (cnt > m) m = cnt;
        end
        o = pack4(s[0], s[1], s[2], s[3]);
        if (EE) lat = (m == 0) ? 3 : ((m == 1) ? 5 : 6);
        else    lat = 6;
    endtask

    // Per-cycle compare against the model.
    logic [15:0] m_out;
    logic [15:0] held_out;
    int          m_sw;
    int          held_sw;
    int          m_lat;
    int          k;
    bit          pending;

    initial begin
        pending  = 0;
        held_out = '0;
        held_sw  = 0;
        k        = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pending  = 0;
            held_out = '0;
            held_sw  = 0;
            chk("rst_ready", sif.ready, 1);
            chk("rst_busy", sif.busy, 0);
            chk("rst_done", sif.done, 0);
            chk("rst_out", sif.out_data, 0);
            chk("rst_swaps", sif.swap_count, 0);
        end else begin
            if (pending) k++;
            chk("busy_done_excl", sif.busy & sif.done, 0);
            if (pending) begin
                chk("ready_run", sif.ready, 0);
                chk("busy_run", sif.busy, (k < m_lat));
                chk("done_run", sif.done, (k == m_lat));
                if (k == m_lat) begin
                    chk("out_model", sif.out_data, m_out);
                    chk("swaps_model", sif.swap_count, m_sw);
                    held_out = m_out;
                    held_sw  = m_sw;
                    pending  = 0;
                end else begin
                    chk("out_hold_run", sif.out_data, held_out);
                end
            end else begin
                chk("ready_idle", sif.ready, 1);
                chk("busy_idle", sif.busy, 0);
                chk("done_idle", sif.done, 0);
                chk("out_hold", sif.out_data, held_out);
                chk("swaps_hold", sif.swap_count, held_sw);
                if (sif.start) begin
                    model_sort(sif.in_data, m_out, m_sw, m_lat);
                    pending = 1;
                    k       = -1;
                end
            end
        end
    end

    // mode 0: plain; 1: extra start pulse around E2; 2: reset between E3 and E4.
    task automatic run_sort(input logic [15:0] in, input logic [15:0] exp_out,
                            input int exp_sw, input int exp_lat, input int mode);
        logic [15:0] mo;
        int ms;
        int ml;
        int e0;
        bit got;
        model_sort(in, mo, ms, ml);
        chk("model_pin_out", mo, exp_out);
        chk("model_pin_swaps", ms, exp_sw);
        chk("model_pin_lat", ml, exp_lat);
        @(posedge clk); #1;
        sif.start   = 1'b1;
        sif.in_data = in;
        @(posedge clk); #1;
        e0 = cyc;
        sif.start = 1'b0;
        if (mode == 1) begin
            @(posedge clk); #1;
            sif.start   = 1'b1;
            sif.in_data = ~in;
            @(posedge clk); #1;
            sif.start = 1'b0;
        end
        if (mode == 2) begin
            repeat (3) @(posedge clk);
            #2 rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
        end
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sif.done) begin
                got = 1;
                break;
            end
        end
        chk("done_seen", got, 1);
        if (got) begin
            chk("out_literal", sif.out_data, exp_out);
            chk("swaps_literal", sif.swap_count, exp_sw);
            chk("latency", cyc - e0, exp_lat);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        sif.start   = 1'b0;
        sif.in_data = '0;
        repeat (3) begin
            @(posedge clk); #1;
            sif.in_data = 16'($urandom);
            sif.start   = 1'($urandom_range(0, 1));
        end
        sif.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_sort(pack4(7, 3, 0, -8),    pack4(-8, 0, 3, 7),   6, 6, 0);
        run_sort(pack4(1, -8, 7, -1),   pack4(-8, -1, 1, 7),  3, 6, 0);
        run_sort(pack4(-2, -2, 5, 5),   pack4(-2, -2, 5, 5),  0, EE ? 3 : 6, 0);
        run_sort(pack4(-1, 2, -3, 4),   pack4(-3, -1, 2, 4),  2, 6, 1);
        run_sort(pack4(1, 0, 2, 3),     pack4(0, 1, 2, 3),    1, EE ? 5 : 6, 0);
        run_sort(pack4(3, -4, 3, -4),   pack4(-4, -4, 3, 3),  3, 6, 2);
        run_sort(pack4(3, -4, 3, -4),   pack4(-4, -4, 3, 3),  3, 6, 0);
        run_sort(pack4(-8, 7, -8, 7),   pack4(-8, -8, 7, 7),  1, EE ? 5 : 6, 0);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
